// File: rtl/cache_mem_arbiter.sv
// Two-port arbiter sharing one line-wide memory port between the D-cache (p0) and I-cache (p1).
// Optional build macro CACHE_MEM_ARB_FIXED_PRIO_EN: p0 wins every conflict instead of round-robin.
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_mem_read,
    input  logic                  p0_mem_write,
    input  logic [ADDR_WIDTH-1:0] p0_mem_read_addr,
    input  logic [ADDR_WIDTH-1:0] p0_mem_write_addr,
    input  logic [LINE_WIDTH-1:0] p0_mem_wr_data,
    output logic                  p0_mem_rd_data_valid,
    output logic                  p0_mem_wr_data_ready,
    input  logic                  p1_mem_read,
    input  logic                  p1_mem_write,
    input  logic [ADDR_WIDTH-1:0] p1_mem_read_addr,
    input  logic [ADDR_WIDTH-1:0] p1_mem_write_addr,
    input  logic [LINE_WIDTH-1:0] p1_mem_wr_data,
    output logic                  p1_mem_rd_data_valid,
    output logic                  p1_mem_wr_data_ready,
    output logic [LINE_WIDTH-1:0] mem_rd_data_out,
    input  logic [LINE_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_data_valid,
    input  logic                  mem_wr_data_ready,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [LINE_WIDTH-1:0] mem_wr_data,
    output logic                  grant,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, WR, RD, HOLD} state_t;

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_read_addr_q, mem_read_addr_d;
    logic [ADDR_WIDTH-1:0] mem_write_addr_q, mem_write_addr_d;
    logic [LINE_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
`ifndef CACHE_MEM_ARB_FIXED_PRIO_EN
    logic                  rr_ptr_q, rr_ptr_d;
`endif

    logic                  req0, req1, winner;
    logic                  win_write, gnt_read;
    logic [ADDR_WIDTH-1:0] win_read_addr, win_write_addr, gnt_read_addr;
    logic [LINE_WIDTH-1:0] win_wr_data;

    always_comb begin
        req0 = p0_mem_read | p0_mem_write;
        req1 = p1_mem_read | p1_mem_write;
`ifdef CACHE_MEM_ARB_FIXED_PRIO_EN
        winner = ~req0;
`else
        winner = (req0 & req1) ? rr_ptr_q : ~req0;
`endif
        win_write      = winner ? p1_mem_write      : p0_mem_write;
        win_read_addr  = winner ? p1_mem_read_addr  : p0_mem_read_addr;
        win_write_addr = winner ? p1_mem_write_addr : p0_mem_write_addr;
        win_wr_data    = winner ? p1_mem_wr_data    : p0_mem_wr_data;
        gnt_read       = grant_q ? p1_mem_read      : p0_mem_read;
        gnt_read_addr  = grant_q ? p1_mem_read_addr : p0_mem_read_addr;

        state_d          = state_q;
        grant_d          = grant_q;
        mem_read_d       = mem_read_q;
        mem_write_d      = mem_write_q;
        mem_read_addr_d  = mem_read_addr_q;
        mem_write_addr_d = mem_write_addr_q;
        mem_wr_data_d    = mem_wr_data_q;
`ifndef CACHE_MEM_ARB_FIXED_PRIO_EN
        rr_ptr_d         = rr_ptr_q;
`endif

        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    grant_d = winner;
                    if (win_write) begin
                        mem_write_d      = 1'b1;
                        mem_write_addr_d = win_write_addr;
                        mem_wr_data_d    = win_wr_data;
                        state_d          = WR;
                    end else begin
                        mem_read_d      = 1'b1;
                        mem_read_addr_d = win_read_addr;
                        state_d         = RD;
                    end
                end
            end
            WR: begin
                if (mem_wr_data_ready) begin
                    mem_write_d      = 1'b0;
                    mem_write_addr_d = '0;
                    mem_wr_data_d    = '0;
                    // A refill paired with this writeback follows without re-arbitration.
                    if (gnt_read) begin
                        mem_read_d      = 1'b1;
                        mem_read_addr_d = gnt_read_addr;
                        state_d         = RD;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            RD: begin
                if (mem_rd_data_valid) begin
                    mem_read_d      = 1'b0;
                    mem_read_addr_d = '0;
                    state_d         = HOLD;
                end
            end
            HOLD: begin
`ifndef CACHE_MEM_ARB_FIXED_PRIO_EN
                rr_ptr_d = ~grant_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            grant_q          <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_read_addr_q  <= '0;
            mem_write_addr_q <= '0;
            mem_wr_data_q    <= '0;
`ifndef CACHE_MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q         <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            grant_q          <= grant_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_read_addr_q  <= mem_read_addr_d;
            mem_write_addr_q <= mem_write_addr_d;
            mem_wr_data_q    <= mem_wr_data_d;
`ifndef CACHE_MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q         <= rr_ptr_d;
`endif
        end
    end

    // Memory responses reach only the granted port, and only in the matching state.
    assign p0_mem_wr_data_ready = (state_q == WR) & ~grant_q & mem_wr_data_ready;
    assign p1_mem_wr_data_ready = (state_q == WR) &  grant_q & mem_wr_data_ready;
    assign p0_mem_rd_data_valid = (state_q == RD) & ~grant_q & mem_rd_data_valid;
    assign p1_mem_rd_data_valid = (state_q == RD) &  grant_q & mem_rd_data_valid;

    assign mem_rd_data_out = mem_rd_data;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_read_addr   = mem_read_addr_q;
    assign mem_write_addr  = mem_write_addr_q;
    assign mem_wr_data     = mem_wr_data_q;
    assign grant           = grant_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized self-checking bench for cache_mem_arbiter with a transaction-level arbitration model.
// Honours CACHE_MEM_ARB_FIXED_PRIO_EN when predicting service order.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   p_read, p_write, p_rd_valid, p_wr_ready;
    logic [31:0]  p_ra [2];
    logic [31:0]  p_wa [2];
    logic [127:0] p_wd [2];
    logic [127:0] mem_rd_data_out, mem_rd_data, mem_wr_data;
    logic         mem_rd_data_valid, mem_wr_data_ready;
    logic         mem_read, mem_write, grant, busy;
    logic [31:0]  mem_read_addr, mem_write_addr;

    // Model state: requested transaction per port and round-robin preference.
    int           kind [2];
    logic [31:0]  ra [2];
    logic [31:0]  wa [2];
    logic [127:0] wd [2];
    logic [127:0] rd_line;
    int           lat;
    int           model_ptr;
    int           vectors = 0;
    int           errors = 0;

    cache_mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .p0_mem_read          (p_read[0]),
        .p0_mem_write         (p_write[0]),
        .p0_mem_read_addr     (p_ra[0]),
        .p0_mem_write_addr    (p_wa[0]),
        .p0_mem_wr_data       (p_wd[0]),
        .p0_mem_rd_data_valid (p_rd_valid[0]),
        .p0_mem_wr_data_ready (p_wr_ready[0]),
        .p1_mem_read          (p_read[1]),
        .p1_mem_write         (p_write[1]),
        .p1_mem_read_addr     (p_ra[1]),
        .p1_mem_write_addr    (p_wa[1]),
        .p1_mem_wr_data       (p_wd[1]),
        .p1_mem_rd_data_valid (p_rd_valid[1]),
        .p1_mem_wr_data_ready (p_wr_ready[1]),
        .mem_rd_data_out      (mem_rd_data_out),
        .mem_rd_data          (mem_rd_data),
        .mem_rd_data_valid    (mem_rd_data_valid),
        .mem_wr_data_ready    (mem_wr_data_ready),
        .mem_read             (mem_read),
        .mem_write            (mem_write),
        .mem_read_addr        (mem_read_addr),
        .mem_write_addr       (mem_write_addr),
        .mem_wr_data          (mem_wr_data),
        .grant                (grant),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serve one port's transaction (write, read, or write followed by read) as the memory model.
    task automatic serve_port(input int p);
        int waited = 0;
        logic [1:0] own = 2'b01 << p;
        @(negedge clk);
        while (!(mem_read | mem_write) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("mem_req_seen", mem_read | mem_write, 1'b1);
        if (!(mem_read | mem_write)) begin
            p_read[p] = 1'b0;
            p_write[p] = 1'b0;
            return;
        end
        checkOutput("grant", grant, p[0]);
        checkOutput("busy_active", busy, 1'b1);
        if (kind[p] >= 2) begin
            checkOutput("mem_write", mem_write, 1'b1);
            checkOutput("mem_read_in_wr", mem_read, 1'b0);
            checkOutput("wr_addr", mem_write_addr, wa[p]);
            checkOutput("wr_data", mem_wr_data, wd[p]);
            p_wd[p] = ~p_wd[p];
            @(negedge clk);
            checkOutput("wr_data_latched", mem_wr_data, wd[p]);
            repeat (lat - 1) @(negedge clk);
            mem_wr_data_ready = 1'b1;
            #1;
            checkOutput("wr_ready_route", p_wr_ready, own);
            checkOutput("rd_valid_in_wr", p_rd_valid, 2'b00);
            p_write[p] = 1'b0;
            @(negedge clk);
            mem_wr_data_ready = 1'b0;
            checkOutput("wr_dropped", mem_write, 1'b0);
            checkOutput("wr_addr_cleared", mem_write_addr, 32'h0);
            if (kind[p] == 2) begin
                checkOutput("hold_busy", busy, 1'b1);
                @(negedge clk);
                checkOutput("idle_after_hold", busy, 1'b0);
                return;
            end
            checkOutput("grant_kept", grant, p[0]);
        end
        checkOutput("mem_read", mem_read, 1'b1);
        checkOutput("rd_addr", mem_read_addr, ra[p]);
        p_ra[p] = p_ra[p] ^ 32'h0000_0100;
        mem_wr_data_ready = 1'($urandom_range(0, 1));
        #1;
        checkOutput("stray_wr_ready", p_wr_ready, 2'b00);
        @(negedge clk);
        mem_wr_data_ready = 1'b0;
        checkOutput("rd_held", mem_read, 1'b1);
        checkOutput("rd_addr_latched", mem_read_addr, ra[p]);
        repeat (lat - 1) @(negedge clk);
        mem_rd_data = rd_line;
        mem_rd_data_valid = 1'b1;
        #1;
        checkOutput("rd_valid_route", p_rd_valid, own);
        checkOutput("rd_data_out", mem_rd_data_out, rd_line);
        p_read[p] = 1'b0;
        @(negedge clk);
        mem_rd_data_valid = 1'b0;
        checkOutput("rd_dropped", mem_read, 1'b0);
        checkOutput("rd_addr_cleared", mem_read_addr, 32'h0);
        checkOutput("hold_busy", busy, 1'b1);
        @(negedge clk);
        checkOutput("idle_after_hold", busy, 1'b0);
    endtask

    // One round: both ports raise the requests in kind[], model predicts service order.
    task automatic applyStimulus(input logic stray_idle);
        int first;
        if (stray_idle) begin
            @(negedge clk);
            mem_rd_data_valid = 1'b1;
            #1;
            checkOutput("stray_rd_valid_idle", p_rd_valid, 2'b00);
            @(negedge clk);
            mem_rd_data_valid = 1'b0;
            checkOutput("idle_after_stray", busy, 1'b0);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            p_read[i]  = (kind[i] == 1 || kind[i] == 3);
            p_write[i] = (kind[i] >= 2);
            p_ra[i] = ra[i];
            p_wa[i] = wa[i];
            p_wd[i] = wd[i];
        end
        if (kind[0] == 0 && kind[1] == 0) return;
`ifdef CACHE_MEM_ARB_FIXED_PRIO_EN
        first = (kind[0] != 0) ? 0 : 1;
`else
        first = (kind[0] != 0 && kind[1] != 0) ? model_ptr : ((kind[0] != 0) ? 0 : 1);
`endif
        serve_port(first);
        model_ptr = 1 - first;
        if (kind[1 - first] != 0) begin
            serve_port(1 - first);
            model_ptr = first;
        end
    endtask

    task automatic randomize_round();
        for (int i = 0; i < 2; i++) begin
            kind[i] = $urandom_range(0, 3);
            ra[i] = $urandom & 32'hFFFF_FFF0;
            wa[i] = $urandom & 32'hFFFF_FFF0;
            wd[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        rd_line = {$urandom, $urandom, $urandom, $urandom};
        lat = $urandom_range(1, 4);
    endtask

    initial begin
        rst = 1'b1;
        p_read = 2'b00;
        p_write = 2'b00;
        for (int i = 0; i < 2; i++) begin
            p_ra[i] = '0;
            p_wa[i] = '0;
            p_wd[i] = '0;
        end
        mem_rd_data = '0;
        mem_rd_data_valid = 1'b0;
        mem_wr_data_ready = 1'b0;
        model_ptr = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_mem_read", mem_read, 1'b0);
        checkOutput("rst_mem_write", mem_write, 1'b0);
        checkOutput("rst_grant", grant, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_wr_data", mem_wr_data, 128'h0);
        checkOutput("rst_resp", {p_rd_valid, p_wr_ready}, 4'h0);
        rst = 1'b0;

        // p0 refill alone
        kind[0] = 1; kind[1] = 0;
        ra[0] = 32'h0000_0100; ra[1] = 32'h0; wa[0] = 32'h0; wa[1] = 32'h0;
        wd[0] = '0; wd[1] = '0;
        rd_line = {4{32'hAAAA_AAAA}};
        lat = 3;
        applyStimulus(1'b1);

        // p0 writeback + refill with p1 also pending
        kind[0] = 3; kind[1] = 1;
        wa[0] = 32'h0000_0200; ra[0] = 32'h0000_0300; ra[1] = 32'h0000_0700;
        wd[0] = {4{32'h1234_5678}};
        rd_line = {4{32'h5555_5555}};
        lat = 2;
        applyStimulus(1'b0);

        // simultaneous refills, twice
        for (int r = 0; r < 2; r++) begin
            kind[0] = 1; kind[1] = 1;
            ra[0] = 32'h0000_0800 + 32'(r * 16); ra[1] = 32'h0000_0900 + 32'(r * 16);
            rd_line = {4{$urandom}};
            lat = 1;
            applyStimulus(1'b0);
        end

        // reset while p1 refill is outstanding
        @(negedge clk);
        p_read[1] = 1'b1;
        p_ra[1] = 32'h0000_0A00;
        @(negedge clk);
        checkOutput("pre_rst_read", mem_read, 1'b1);
        checkOutput("pre_rst_grant", grant, 1'b1);
        rst = 1'b1;
        p_read[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_mem_read", mem_read, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_grant", grant, 1'b0);
        checkOutput("abort_rd_addr", mem_read_addr, 32'h0);
        model_ptr = 0;

        // p1 refill after reset, address changed mid-read inside serve_port
        kind[0] = 0; kind[1] = 1;
        ra[1] = 32'h0000_0400;
        rd_line = {4{32'hC0DE_F00D}};
        lat = 3;
        applyStimulus(1'b0);

        for (int r = 0; r < 40; r++) begin
            randomize_round();
            applyStimulus(1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
